regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Arbitrates the single register-file write port among three writeback sources: ALU result, data-memory load, and link/LUI (return address or upper immediate). Grants at most one write per cycle under an aging fixed-priority policy. Drives a registered write port into the register file and keeps a pending-write scoreboard that decode uses for RAW stalls. Sits between the execute/memory stages and the register file.

## Interface
- MAX_WAIT, 4: cycles a valid requester may be refused before it is forced to top priority (1..15)
- XLEN, 32: data width
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid / alu_ready  in / out  1  ALU write request handshake
- alu_rd, alu_data  in  5, XLEN  ALU destination and value
- ld_valid / ld_ready  in / out  1  load write request handshake
- ld_rd, ld_data  in  5, XLEN  load destination and value (already byte-extended)
- lnk_valid / lnk_ready  in / out  1  link/LUI write request handshake
- lnk_rd, lnk_data  in  5, XLEN  link/LUI destination and value
- sb_set  in  1  decode issued an instruction that will write sb_rd
- sb_rd  in  5  destination to mark pending
- rs1, rs2  in  5  decode source registers to check
- rs1_busy, rs2_busy  out  1  source has a pending write (combinational from scoreboard)
- flush  in  1  pipeline flush: clear scoreboard and wait counters
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  5  register-file write address (registered)
- wr_data  out  XLEN  register-file write data (registered)

## Operation
- Requester indices: ld=0, lnk=1, alu=2. Base priority ld > lnk > alu.
- Per requester, a wait counter wc[i] (4 bits): if valid and not granted, increments, saturating at MAX_WAIT; cleared on grant or when valid is low.
- Aged set = requesters with valid and wc==MAX_WAIT. If non-empty, grant the highest-base-priority aged requester; otherwise grant the highest-base-priority valid requester. No valid requests: no grant.
- ready[i] = grant[i], combinational; at most one ready high per cycle. Requester must hold valid, rd, and data stable until ready. Transfer occurs on a cycle with valid && ready.
- On a transfer with rd!=0: at that edge, wr_en<=1, wr_addr<=rd, wr_data<=data. With rd==0, the transfer still completes (ready=1), but wr_en<=0 and nothing is written.
- No transfer: wr_en<=0. wr_addr and wr_data hold their previous values.
- Scoreboard pending[31:0]: sb_set with sb_rd!=0 sets pending[sb_rd]; sb_rd==0 is ignored; pending[0] is always 0.
- Clear: on an edge where wr_en==1, pending[wr_addr] clears (same edge the register file captures the data).
- Same register set and cleared on the same edge: set wins.
- rsN_busy = pending[rsN]; rsN==0 gives 0.
- flush: all pending bits and wait counters go to 0 at the edge. Set in the same cycle is ignored. A transfer in the same cycle still completes, and its wr_en is still issued.

## Timing
- Reset (reset_n low, asynchronous, any time incl. mid-transfer): wr_en=0, wr_addr=0, wr_data=0, pending=0, all wc=0. All ready outputs forced 0 while reset_n is low.
- Grant-to-write latency: 1 cycle (transfer at edge t, wr_en high during cycle t+1, register file written at edge t+1).
- Busy latency: sb_set at edge t gives busy during cycle t+1. After a write at edge t+1, busy is 0 from cycle t+2, and the register file already holds the data.
- Throughput: one write per cycle; back-to-back transfers allowed.
- Starvation bound: a continuously valid requester is granted within MAX_WAIT+1 cycles, or within 2·(MAX_WAIT+1) if two requesters age simultaneously.

## Test plan
- Reset mid-operation: drive all three valid and pull reset_n low asynchronously -> all outputs and ready 0 immediately; pending reads 0 after release.
- Single ALU write alu_rd=5, alu_data=0x0800_0005 -> alu_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0x0800_0005; then wr_en=0.
- Continuous contention, all three valid every cycle with new data, MAX_WAIT=4 -> ld granted cycle 0, alu granted no later than cycle 5; never two ready in one cycle; every accepted value appears on wr_data exactly once, in grant order.
- x0 handling: ld_valid with ld_rd=0, and sb_set with sb_rd=0 -> ld_ready=1, wr_en stays 0, rs1_busy for rs1=0 stays 0.
- Scoreboard: sb_set rd=8 at edge 0 -> rs1=8 busy in cycle 1. ALU write rd=8 transfers at edge 3 -> wr_en in cycle 4, busy 0 in cycle 5. Repeat with sb_set rd=8 at edge 4 -> busy stays 1.
- Flush: pending {5,8}, flush with a simultaneous lnk transfer rd=5 -> pending all 0 next cycle, wr_en=1 with wr_addr=5 still issued.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request channels, scoreboard port and register-file write port
interface regfile_wb_arbiter_if #(parameter int XLEN = 32);
   logic            alu_valid, alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            ld_valid, ld_ready;
   logic [4:0]      ld_rd;
   logic [XLEN-1:0] ld_data;
   logic            lnk_valid, lnk_ready;
   logic [4:0]      lnk_rd;
   logic [XLEN-1:0] lnk_data;
   logic            sb_set, flush;
   logic [4:0]      sb_rd, rs1, rs2;
   logic            rs1_busy, rs2_busy;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;
   modport master (
      output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
             lnk_valid, lnk_rd, lnk_data, sb_set, sb_rd, rs1, rs2, flush,
      input  alu_ready, ld_ready, lnk_ready, rs1_busy, rs2_busy, wr_en, wr_addr, wr_data
   );
   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
             lnk_valid, lnk_rd, lnk_data, sb_set, sb_rd, rs1, rs2, flush,
      output alu_ready, ld_ready, lnk_ready, rs1_busy, rs2_busy, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: aging fixed-priority writeback arbiter with registered write port and RAW scoreboard
module regfile_wb_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int XLEN     = 32
) (
   input logic              clk,
   input logic              reset_n,
   regfile_wb_arbiter_if.slave bus
);
   localparam logic [3:0] MW = 4'(MAX_WAIT);
   logic [2:0]      vld, aged, pick, gnt;
   logic [3:0]      wc [3];
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic [31:0]     pending, pend_nxt;
   logic            wr;
   // index order ld=0, lnk=1, alu=2 doubles as base priority
   always_comb begin
      vld = {bus.alu_valid, bus.lnk_valid, bus.ld_valid};
      for (int i = 0; i < 3; i++) aged[i] = vld[i] && wc[i] == MW;
      pick = |aged ? aged : vld;
      gnt = pick[0] ? 3'b001 : pick[1] ? 3'b010 : pick[2] ? 3'b100 : 3'b000;
      sel_rd = gnt[0] ? bus.ld_rd : gnt[1] ? bus.lnk_rd : bus.alu_rd;
      sel_data = gnt[0] ? bus.ld_data : gnt[1] ? bus.lnk_data : bus.alu_data;
      wr = |gnt && sel_rd != 5'd0;
      pend_nxt = pending;
      if (bus.wr_en) pend_nxt[bus.wr_addr] = 1'b0;
      if (bus.sb_set) pend_nxt[bus.sb_rd] = 1'b1;
      pend_nxt[0] = 1'b0;
      if (bus.flush) pend_nxt = '0;
   end
   assign bus.ld_ready  = gnt[0] & reset_n;
   assign bus.lnk_ready = gnt[1] & reset_n;
   assign bus.alu_ready = gnt[2] & reset_n;
   assign bus.rs1_busy  = pending[bus.rs1];
   assign bus.rs2_busy  = pending[bus.rs2];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         pending     <= '0;
         for (int i = 0; i < 3; i++) wc[i] <= '0;
      end else begin
         bus.wr_en <= wr;
         if (wr) begin
            bus.wr_addr <= sel_rd;
            bus.wr_data <= sel_data;
         end
         pending <= pend_nxt;
         for (int i = 0; i < 3; i++)
            wc[i] <= (bus.flush || !vld[i] || gnt[i]) ? 4'd0 : wc[i] == MW ? wc[i] : wc[i] + 4'd1;
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks against a behavioural writeback/scoreboard model
module tb_regfile_wb_arbiter;
   localparam int MW = 4;
   logic clk, reset_n;
   regfile_wb_arbiter_if #(.XLEN(32)) bus();
   regfile_wb_arbiter #(.MAX_WAIT(MW), .XLEN(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   bit          v [3];
   logic [4:0]  rdv [3];
   logic [31:0] dv [3];
   bit          sb_set, flush;
   logic [4:0]  sb_rd, rs1, rs2;
   int          wcm [3];
   bit [31:0]   pend_m;
   bit          we_m;
   bit [4:0]    wa_m;
   bit [31:0]   wd_m;
   int          n_checks, n_fail;

   assign bus.ld_valid  = v[0];
   assign bus.ld_rd     = rdv[0];
   assign bus.ld_data   = dv[0];
   assign bus.lnk_valid = v[1];
   assign bus.lnk_rd    = rdv[1];
   assign bus.lnk_data  = dv[1];
   assign bus.alu_valid = v[2];
   assign bus.alu_rd    = rdv[2];
   assign bus.alu_data  = dv[2];
   assign bus.sb_set    = sb_set;
   assign bus.sb_rd     = sb_rd;
   assign bus.rs1       = rs1;
   assign bus.rs2       = rs2;
   assign bus.flush     = flush;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_grant();
      for (int i = 0; i < 3; i++) if (v[i] && wcm[i] == MW) return i;
      for (int i = 0; i < 3; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [2:0] rdy_vec();
      return {bus.alu_ready, bus.lnk_ready, bus.ld_ready};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) wcm[i] = 0;
      pend_m = '0; we_m = 0; wa_m = '0; wd_m = '0;
   endtask

   task automatic idle();
      for (int i = 0; i < 3; i++) begin v[i] = 0; rdv[i] = '0; dv[i] = '0; end
      sb_set = 0; sb_rd = '0; flush = 0; rs1 = '0; rs2 = '0;
   endtask

   // Advance the model across one rising edge, then the DUT; returns at edge+1
   task automatic tick();
      int g;
      bit [31:0] np;
      g = model_grant();
      np = pend_m;
      if (we_m) np[wa_m] = 0;
      if (sb_set && sb_rd != 0) np[sb_rd] = 1;
      if (flush) np = '0;
      pend_m = np;
      for (int i = 0; i < 3; i++)
         wcm[i] = (flush || !v[i] || i == g) ? 0 : (wcm[i] < MW ? wcm[i] + 1 : MW);
      we_m = g >= 0 && rdv[g] != 0;
      if (we_m) begin wa_m = rdv[g]; wd_m = dv[g]; end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 0; idle(); model_reset();
      @(posedge clk); #1; @(posedge clk); #1;
      n_checks++;
      if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin
         n_fail++; $display("FAIL reset_init: en=%b addr=%0d data=%h want 0/0/0", bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      reset_n = 1;
      v = '{1, 1, 1}; rdv = '{3, 4, 5}; dv = '{32'h11, 32'h22, 32'h33};
      sb_set = 1; sb_rd = 7;
      tick(); sb_set = 0; tick();
      #2 reset_n = 0; #1;
      n_checks++;
      if (rdy_vec() !== 3'b000) begin
         n_fail++; $display("FAIL reset_ready: got %b want 000", rdy_vec());
      end
      n_checks++;
      if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin
         n_fail++; $display("FAIL reset_async: en=%b addr=%0d data=%h want 0/0/0", bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      idle(); model_reset(); tick();
      reset_n = 1; rs1 = 7; rs2 = 3; #1;
      n_checks++;
      if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_pending: busy1=%b busy2=%b want 0/0", bus.rs1_busy, bus.rs2_busy);
      end
      tick();
   endtask

   task automatic test_single_alu();
      idle(); v[2] = 1; rdv[2] = 5; dv[2] = 32'h0800_0005; #1;
      n_checks++;
      if (rdy_vec() !== 3'b100) begin
         n_fail++; $display("FAIL alu_ready: got %b want 100", rdy_vec());
      end
      tick(); v[2] = 0; #1;
      n_checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'h0800_0005) begin
         n_fail++; $display("FAIL alu_write: en=%b addr=%0d data=%h want 1/5/08000005", bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      tick(); #1;
      n_checks++;
      if (bus.wr_en !== 1'b0) begin
         n_fail++; $display("FAIL alu_write_done: en=%b want 0", bus.wr_en);
      end
   endtask

   task automatic test_contention();
      bit [36:0] q [$];
      bit [36:0] e;
      int first_alu, g;
      logic [2:0] gv;
      idle(); tick();
      for (int i = 0; i < 3; i++) begin v[i] = 1; rdv[i] = 5'($urandom_range(1, 31)); dv[i] = $urandom; end
      first_alu = -1;
      for (int c = 0; c < 12; c++) begin
         #1; gv = rdy_vec(); g = model_grant();
         n_checks++;
         if ($countones(gv) > 1 || (c == 0 && gv !== 3'b001) || gv !== 3'(1 << g)) begin
            n_fail++; $display("FAIL contention_grant: cycle %0d got %b want %b", c, gv, 3'(1 << g));
         end
         if (gv[2] && first_alu < 0) first_alu = c;
         if (bus.wr_en) begin
            e = q.size() ? q.pop_front() : '1;
            n_checks++;
            if ({bus.wr_addr, bus.wr_data} !== e) begin
               n_fail++; $display("FAIL contention_order: got %0d/%h want %0d/%h", bus.wr_addr, bus.wr_data, e[36:32], e[31:0]);
            end
         end
         if (g >= 0) q.push_back({rdv[g], dv[g]});
         tick();
         if (g >= 0) begin rdv[g] = 5'($urandom_range(1, 31)); dv[g] = $urandom; end
      end
      n_checks++;
      if (first_alu < 0 || first_alu > MW + 1) begin
         n_fail++; $display("FAIL contention_starve: alu first grant cycle %0d want 0..%0d", first_alu, MW + 1);
      end
      idle(); #1;
      if (bus.wr_en) begin
         e = q.size() ? q.pop_front() : '1;
         n_checks++;
         if ({bus.wr_addr, bus.wr_data} !== e) begin
            n_fail++; $display("FAIL contention_last: got %0d/%h want %0d/%h", bus.wr_addr, bus.wr_data, e[36:32], e[31:0]);
         end
      end
      tick();
      n_checks++;
      if (q.size() != 0 || bus.wr_en !== 1'b0) begin
         n_fail++; $display("FAIL contention_drain: %0d values never written, en=%b", q.size(), bus.wr_en);
      end
   endtask

   task automatic test_x0();
      idle(); v[0] = 1; rdv[0] = 0; dv[0] = $urandom; sb_set = 1; sb_rd = 0; rs1 = 0; #1;
      n_checks++;
      if (bus.ld_ready !== 1'b1 || bus.rs1_busy !== 1'b0) begin
         n_fail++; $display("FAIL x0_ready: ready=%b busy=%b want 1/0", bus.ld_ready, bus.rs1_busy);
      end
      tick(); idle(); #1;
      n_checks++;
      if (bus.wr_en !== 1'b0 || bus.rs1_busy !== 1'b0) begin
         n_fail++; $display("FAIL x0_write: en=%b busy=%b want 0/0", bus.wr_en, bus.rs1_busy);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      for (int rep = 0; rep < 2; rep++) begin
         idle(); rs1 = 8; sb_set = 1; sb_rd = 8;
         tick(); sb_set = 0; #1;
         n_checks++;
         if (bus.rs1_busy !== 1'b1) begin
            n_fail++; $display("FAIL sb_set: busy=%b want 1", bus.rs1_busy);
         end
         tick(); tick();
         v[2] = 1; rdv[2] = 8; dv[2] = $urandom; #1;
         n_checks++;
         if (bus.alu_ready !== 1'b1) begin
            n_fail++; $display("FAIL sb_alu_ready: got %b want 1", bus.alu_ready);
         end
         tick(); v[2] = 0;
         if (rep == 1) begin sb_set = 1; sb_rd = 8; end
         #1;
         n_checks++;
         if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd8 || bus.rs1_busy !== 1'b1) begin
            n_fail++; $display("FAIL sb_write: en=%b addr=%0d busy=%b want 1/8/1", bus.wr_en, bus.wr_addr, bus.rs1_busy);
         end
         tick(); sb_set = 0; #1;
         n_checks++;
         if (bus.rs1_busy !== (rep == 1)) begin
            n_fail++; $display("FAIL sb_clear: rep %0d busy=%b want %b", rep, bus.rs1_busy, rep == 1);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] d;
      idle(); sb_set = 1; sb_rd = 5; tick(); sb_rd = 8; tick();
      sb_set = 0; rs1 = 5; rs2 = 8; #1;
      n_checks++;
      if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
         n_fail++; $display("FAIL flush_pre: busy=%b%b want 11", bus.rs1_busy, bus.rs2_busy);
      end
      d = $urandom; v[1] = 1; rdv[1] = 5; dv[1] = d; flush = 1; sb_set = 1; sb_rd = 9;
      tick(); idle(); rs1 = 5; rs2 = 9; #1;
      n_checks++;
      if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
         n_fail++; $display("FAIL flush_pending: busy=%b%b want 00", bus.rs1_busy, bus.rs2_busy);
      end
      n_checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== d) begin
         n_fail++; $display("FAIL flush_write: en=%b addr=%0d data=%h want 1/5/%h", bus.wr_en, bus.wr_addr, bus.wr_data, d);
      end
      rs2 = 8; #1;
      n_checks++;
      if (bus.rs2_busy !== 1'b0) begin
         n_fail++; $display("FAIL flush_r8: busy=%b want 0", bus.rs2_busy);
      end
      tick();
   endtask

   task automatic test_random();
      int g;
      idle();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++)
            if (!v[i] && $urandom_range(0, 1)) begin v[i] = 1; rdv[i] = 5'($urandom); dv[i] = $urandom; end
         sb_set = $urandom_range(0, 2) == 0; sb_rd = 5'($urandom);
         rs1 = 5'($urandom); rs2 = 5'($urandom); flush = $urandom_range(0, 15) == 0;
         #1; g = model_grant();
         n_checks++;
         if (rdy_vec() !== (g < 0 ? 3'b000 : 3'(1 << g))) begin
            n_fail++; $display("FAIL rand_grant: cycle %0d got %b want %b", c, rdy_vec(), g < 0 ? 3'b000 : 3'(1 << g));
         end
         n_checks++;
         if (bus.rs1_busy !== pend_m[rs1] || bus.rs2_busy !== pend_m[rs2]) begin
            n_fail++; $display("FAIL rand_busy: cycle %0d got %b%b want %b%b", c, bus.rs1_busy, bus.rs2_busy, pend_m[rs1], pend_m[rs2]);
         end
         n_checks++;
         if (bus.wr_en !== we_m || (we_m && (bus.wr_addr !== wa_m || bus.wr_data !== wd_m))) begin
            n_fail++; $display("FAIL rand_write: cycle %0d got %b/%0d/%h want %b/%0d/%h", c, bus.wr_en, bus.wr_addr, bus.wr_data, we_m, wa_m, wd_m);
         end
         tick();
         if (g >= 0) begin v[g] = $urandom_range(0, 1); rdv[g] = 5'($urandom); dv[g] = $urandom; end
      end
      idle(); tick();
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      test_reset();
      test_single_alu();
      test_contention();
      test_x0();
      test_scoreboard();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
